// File: rtl/vcache_req_arbiter.sv
// vcache_req_arbiter: round-robin N:1 vcache request arbiter with an in-order id FIFO that routes responses back.
// Optional per-requester grant/stall counters when VCACHE_REQ_ARBITER_STATS_EN is defined.
module vcache_req_arbiter #(
  parameter int num_req_p = 4,
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32,
  parameter int els_p = 8,
  localparam int pkt_width_lp = 6 + addr_width_p + data_width_p + data_width_p / 8,
  localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_req_p-1:0]              req_v_i,
  input  logic [num_req_p*pkt_width_lp-1:0] req_pkt_i,
  output logic [num_req_p-1:0]              req_ready_o,
  output logic                              cache_v_o,
  output logic [pkt_width_lp-1:0]           cache_pkt_o,
  input  logic                              cache_ready_i,
  input  logic                              cache_v_i,
  input  logic [data_width_p-1:0]           cache_data_i,
  output logic                              cache_yumi_o,
  output logic [num_req_p-1:0]              resp_v_o,
  output logic [data_width_p-1:0]           resp_data_o,
  input  logic [num_req_p-1:0]              resp_yumi_i,
`ifdef VCACHE_REQ_ARBITER_STATS_EN
  output logic [num_req_p*32-1:0]           stat_grant_o,
  output logic [num_req_p*32-1:0]           stat_stall_o,
`endif
  output logic                              err_o
);
  localparam int ptr_w_lp = $clog2(els_p);
  logic [id_width_lp-1:0] last_q, last_d, grant_id, head_id;
  logic [id_width_lp-1:0] mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, rptr_q;
  logic [ptr_w_lp:0] cnt_q, cnt_d;
  logic [pkt_width_lp-1:0] pkts [num_req_p];
  logic err_q, err_d, full, empty, any_v, push, pop, resp_ok;
  for (genvar g = 0; g < num_req_p; g++) begin : g_pkt
    assign pkts[g] = req_pkt_i[g*pkt_width_lp +: pkt_width_lp];
  end
  assign full = cnt_q == (ptr_w_lp+1)'(els_p);
  assign empty = cnt_q == '0;
  assign any_v = |req_v_i;
  assign cache_v_o = any_v & ~full;
  assign push = cache_v_o & cache_ready_i;
  assign head_id = mem_q[rptr_q];
  assign resp_ok = cache_v_i & ~empty;
  assign pop = resp_ok & resp_yumi_i[head_id];
  assign cache_yumi_o = pop;
  assign resp_data_o = cache_data_i;
  assign cache_pkt_o = any_v ? pkts[grant_id] : '0;
  assign err_o = err_q;
  assign cnt_d = cnt_q + (ptr_w_lp+1)'(push) - (ptr_w_lp+1)'(pop);
  assign last_d = push ? grant_id : last_q;
  assign err_d = err_q | (cache_v_i & empty);
  // lowest requester above last_q wins; otherwise lowest at or below it (wrap)
  always_comb begin
    grant_id = last_q;
    for (int i = num_req_p - 1; i >= 0; i--)
      if (req_v_i[i] && i <= int'(last_q)) grant_id = id_width_lp'(i);
    for (int i = num_req_p - 1; i >= 0; i--)
      if (req_v_i[i] && i > int'(last_q)) grant_id = id_width_lp'(i);
  end
  always_comb begin
    req_ready_o = '0;
    req_ready_o[grant_id] = push;
    resp_v_o = '0;
    resp_v_o[head_id] = resp_ok;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      last_q <= id_width_lp'(num_req_p - 1);
      err_q <= 1'b0;
    end else begin
      if (push) mem_q[wptr_q] <= grant_id;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
      last_q <= last_d;
      err_q <= err_d;
    end
  end
`ifdef VCACHE_REQ_ARBITER_STATS_EN
  logic [31:0] grant_cnt_q [num_req_p];
  logic [31:0] stall_cnt_q [num_req_p];
  for (genvar g = 0; g < num_req_p; g++) begin : g_stat
    always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
        grant_cnt_q[g] <= '0;
        stall_cnt_q[g] <= '0;
      end else begin
        if (req_v_i[g] & req_ready_o[g] & ~&grant_cnt_q[g]) grant_cnt_q[g] <= grant_cnt_q[g] + 1'b1;
        if (req_v_i[g] & ~req_ready_o[g] & ~&stall_cnt_q[g]) stall_cnt_q[g] <= stall_cnt_q[g] + 1'b1;
      end
    end
    assign stat_grant_o[g*32 +: 32] = grant_cnt_q[g];
    assign stat_stall_o[g*32 +: 32] = stall_cnt_q[g];
  end
`endif
endmodule

// File: doc/vcache_req_arbiter.md
VCACHE_REQ_ARBITER -- requirements
Module: vcache_req_arbiter

Interface
REQ-001 Parameter: num_req_p, default 4, number of requesters sharing one vcache (2..16).
REQ-002 Parameter: addr_width_p, default 32, cache packet address width.
REQ-003 Parameter: data_width_p, default 32, cache data width.
REQ-004 Parameter: els_p, default 8, maximum outstanding requests; power of two, 2..64.
REQ-005 Derived: pkt_width_lp = bsg_cache_pkt_width(addr_width_p,data_width_p); id_width_lp = max(1,clog2(num_req_p)).
REQ-006 clk_i  in  1  single clock; all state updates on posedge.
REQ-007 reset_n_i  in  1  synchronous, active-low reset.
REQ-008 req_v_i  in  num_req_p  per-requester packet valid.
REQ-009 req_pkt_i  in  num_req_p*pkt_width_lp  packed packets; requester i occupies slice i.
REQ-010 req_ready_o  out  num_req_p  one-hot grant; packet i accepted when req_v_i[i] & req_ready_o[i].
REQ-011 cache_v_o / cache_pkt_o / cache_ready_i  out 1 / out pkt_width_lp / in 1  vcache request port.
REQ-012 cache_v_i / cache_data_i / cache_yumi_o  in 1 / in data_width_p / out 1  vcache in-order response port.
REQ-013 resp_v_o / resp_data_o / resp_yumi_i  out num_req_p / out data_width_p / in num_req_p  per-requester responses; data is shared across requesters.
REQ-014 err_o  out  1  sticky protocol error: response arrived with no outstanding request.

Function
REQ-015 The block SHALL keep an id FIFO of depth els_p recording the granted requester id of each accepted request, in order.
REQ-016 cache_v_o SHALL equal (|req_v_i) & ~fifo_full, combinationally.
REQ-017 The grant SHALL be round-robin: the first requester with req_v_i set, searching from last_r+1 upward with wrap to 0; last_r resets to num_req_p-1.
REQ-018 cache_pkt_o SHALL equal the granted slice of req_pkt_i; it is 0 when no request is valid.
REQ-019 req_ready_o[g] SHALL equal cache_ready_i & cache_v_o for granted g; all other bits are 0.
REQ-020 On handshake (cache_v_o & cache_ready_i), the block SHALL push g into the FIFO and set last_r <= g; zero-bubble, one grant per cycle maximum.
REQ-021 When the FIFO is full, the block SHALL accept no request, even if a pop occurs that same cycle; the full cycle costs one bubble.
REQ-022 Responses: resp_v_o[head] = cache_v_i & ~fifo_empty, other bits 0; resp_data_o = cache_data_i.
REQ-023 cache_yumi_o SHALL equal resp_yumi_i[head] & cache_v_i & ~fifo_empty; it pops the FIFO.
REQ-024 A simultaneous push and pop SHALL leave the occupancy unchanged and preserve order.
REQ-025 On cache_v_i with an empty FIFO, the block SHALL set err_o, keep resp_v_o at 0 and cache_yumi_o at 0, and hold err_o until reset.
REQ-026 Counters and pointers SHALL wrap modulo els_p; the occupancy counter is clog2(els_p)+1 bits wide.
REQ-027 Request selection SHALL be independent of resp_yumi_i; the two ports are fully concurrent.

Reset
REQ-028 While reset_n_i=0 at posedge: FIFO empty, last_r=num_req_p-1, err_o=0; outputs follow REQ-016..023 with the empty FIFO.
REQ-029 Reset mid-operation SHALL discard all outstanding ids; responses after reset with no request set err_o per REQ-025.

Configuration
REQ-030 Macro VCACHE_REQ_ARBITER_STATS_EN: when defined, the block SHALL keep a 32-bit saturating grant counter and a 32-bit saturating stall counter per requester. Stall = req_v_i[i] & ~req_ready_o[i]. Counters are cleared by reset and exposed on output stat_grant_o and output stat_stall_o (num_req_p*32 each).
REQ-031 Without VCACHE_REQ_ARBITER_STATS_EN, these ports and counters SHALL be absent, and the functional behaviour SHALL be identical.

Verification
REQ-032 num_req_p=4; all req_v_i=1111, cache_ready_i=1 for 8 cycles, responses drained each cycle -> grant order 0,1,2,3,0,1,2,3.
REQ-033 els_p=8, cache_v_i=0; 10 back-to-back requests from requester 2 -> 8 accepted, cache_v_o=0 from cycle 9; one pop -> accept resumes the next cycle, not the same cycle.
REQ-034 Accept requests from ids 3,1,0; return 3 responses with data 0xA,0xB,0xC -> resp_v_o shows 1000,0010,0001 with matching data in order.
REQ-035 resp_yumi_i held 0 for 5 cycles with cache_v_i=1 -> cache_yumi_o=0 and the FIFO holds; requests continue to be accepted until full.
REQ-036 cache_v_i=1 after reset with no requests -> err_o=1 next cycle and stays 1; reset_n_i=0 clears it.
REQ-037 With VCACHE_REQ_ARBITER_STATS_EN: requester 1 stalled 3 cycles then granted -> stat_stall_o slice 1 = 3, stat_grant_o slice 1 = 1.
